ps2_cmd_ctrl: RTL and testbench

Sequences the raw PS/2 scan-code stream into discrete Pacman game commands. It sits between the keyboard controller output (`ps2_key_pressed` / `ps2_key_data`) and the game processor. It tracks make/break/extended prefixes and suppresses typematic repeats. It queues commands in a small FIFO, and the processor drains that FIFO through a valid/ready handshake.

---
 rtl/ps2_cmd_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ps2_cmd_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ps2_cmd_ctrl.sv
// ps2_cmd_ctrl: turns a raw PS/2 scan-code byte stream into Pacman game
// commands (UP/DOWN/LEFT/RIGHT/PAUSE/RESTART). It tracks E0/F0 prefixes,
// suppresses typematic repeats of the held direction key, and queues
// commands in a DEPTH-entry FIFO that a valid/ready consumer drains.
// Optional build macro: PS2_WASD_EN also maps the W/S/A/D letter keys as
// directions. These keys are tracked separately from the arrows for repeat
// detection.
module ps2_cmd_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_data,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_data,
  output logic       held_valid,
  output logic [1:0] held_dir,
  output logic [7:0] drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state;
  logic [2:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            held_wasd;

  logic            is_code;
  logic            is_break;
  logic            is_ext;
  logic            hit;
  logic [2:0]      code;
  logic            is_dir;
  logic            wasd;
  logic            make;
  logic            brk;
  logic            same_held;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            full;
  logic            drop;
  logic [AW-1:0]   rd_next;
  logic [CW-1:0]   remain;
  logic [2:0]      head_next;

  // Saturating increment for the drop counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Classify the incoming byte: is it a completing code, a break, extended?
  always_comb begin
    is_code  = 1'b0;
    is_break = 1'b0;
    is_ext   = 1'b0;
    unique case (state)
      IDLE:    is_code = (key_data != 8'hE0) && (key_data != 8'hF0);
      EXT: begin
        is_code = (key_data != 8'hE0) && (key_data != 8'hF0);
        is_ext  = 1'b1;
      end
      BRK:     begin is_code = 1'b1; is_break = 1'b1; end
      EXT_BRK: begin is_code = 1'b1; is_break = 1'b1; is_ext = 1'b1; end
      default: is_code = 1'b0;
    endcase
  end

  // Map a completed (extended flag, code) pair onto a game command.
  always_comb begin
    hit    = 1'b0;
    code   = 3'd0;
    is_dir = 1'b0;
    wasd   = 1'b0;
    if (is_ext) begin
      case (key_data)
        8'h75:   begin hit = 1'b1; code = 3'd0; is_dir = 1'b1; end
        8'h72:   begin hit = 1'b1; code = 3'd1; is_dir = 1'b1; end
        8'h6B:   begin hit = 1'b1; code = 3'd2; is_dir = 1'b1; end
        8'h74:   begin hit = 1'b1; code = 3'd3; is_dir = 1'b1; end
        default: hit = 1'b0;
      endcase
    end else begin
      case (key_data)
        8'h29:   begin hit = 1'b1; code = 3'd4; end
        8'h76:   begin hit = 1'b1; code = 3'd5; end
`ifdef PS2_WASD_EN
        8'h1D:   begin hit = 1'b1; code = 3'd0; is_dir = 1'b1; wasd = 1'b1; end
        8'h1B:   begin hit = 1'b1; code = 3'd1; is_dir = 1'b1; wasd = 1'b1; end
        8'h1C:   begin hit = 1'b1; code = 3'd2; is_dir = 1'b1; wasd = 1'b1; end
        8'h23:   begin hit = 1'b1; code = 3'd3; is_dir = 1'b1; wasd = 1'b1; end
`endif
        default: hit = 1'b0;
      endcase
    end
  end

  assign make      = key_valid && is_code && hit && !is_break;
  assign brk       = key_valid && is_code && hit && is_break;
  // The held key is identified by direction plus source (arrow vs letter).
  assign same_held = held_valid && (held_dir == code[1:0]) && (held_wasd == wasd);
  assign push_req  = make && !(is_dir && same_held);
  assign cmd_valid = (count != '0);
  assign pop       = cmd_valid && cmd_ready;
  assign full      = (count == CW'(DEPTH));
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && !push_ok;
  assign rd_next   = pop ? rd_ptr + AW'(1) : rd_ptr;
  assign remain    = count - CW'(pop);

  // Next registered head: the entry at the post-pop read pointer, or the
  // incoming command when it lands in an otherwise empty queue.
  always_comb begin
    head_next = cmd_data;
    if (remain == '0) begin
      if (push_ok) head_next = code;
    end else begin
      head_next = mem[rd_next];
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= code;
  end

  // Decoder FSM, held-key tracking, FIFO pointers and registered head.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cmd_data   <= 3'd0;
      held_valid <= 1'b0;
      held_dir   <= 2'd0;
      held_wasd  <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (key_valid) begin
        unique case (state)
          IDLE: begin
            if (key_data == 8'hE0)      state <= EXT;
            else if (key_data == 8'hF0) state <= BRK;
            else                        state <= IDLE;
          end
          EXT: begin
            if (key_data == 8'hF0)      state <= EXT_BRK;
            else if (key_data == 8'hE0) state <= EXT;
            else                        state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (make && is_dir) begin
        held_valid <= 1'b1;
        held_dir   <= code[1:0];
        held_wasd  <= wasd;
      end else if (brk && is_dir && same_held) begin
        held_valid <= 1'b0;
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_next;
      count    <= remain + CW'(push_ok);
      cmd_data <= head_next;
      if (drop) drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed testbench for ps2_cmd_ctrl (DEPTH = 4). Define PS2_WASD_EN for
// both files to exercise the letter-key mapping.
module tb_ps2_cmd_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_data;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_data;
  logic       held_valid;
  logic [1:0] held_dir;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  ps2_cmd_ctrl #(.DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .held_valid (held_valid),
    .held_dir   (held_dir),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Drive one byte for one cycle; starts and ends on a falling edge.
  task automatic send(input logic [7:0] b);
    key_valid = 1'b1;
    key_data  = b;
    @(negedge clock);
    key_valid = 1'b0;
  endtask

  // Drive one byte while also accepting the head command in the same cycle.
  task automatic send_pop(input logic [7:0] b);
    key_valid = 1'b1;
    key_data  = b;
    cmd_ready = 1'b1;
    @(negedge clock);
    key_valid = 1'b0;
    cmd_ready = 1'b0;
  endtask

  // Check the head command is present, then pop it.
  task automatic pop_expect(input string tag, input logic [2:0] exp);
    check({tag, "_valid"}, cmd_valid, 1);
    check({tag, "_data"}, cmd_data, exp);
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_data  = 8'h00;
    cmd_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    check("rst_valid", cmd_valid, 0);
    check("rst_data", cmd_data, 0);
    check("rst_held_valid", held_valid, 0);
    check("rst_held_dir", held_dir, 0);
    check("rst_drop", drop_count, 0);

    // Extended UP make, then idle byte with key_valid low is ignored.
    send(8'hE0);
    check("ext_pending_valid", cmd_valid, 0);
    send(8'h75);
    check("up_valid", cmd_valid, 1);
    check("up_data", cmd_data, 0);
    check("up_held_valid", held_valid, 1);
    check("up_held_dir", held_dir, 0);
    key_data = 8'h29;
    @(negedge clock);
    check("no_strobe_data", cmd_data, 0);
    pop_expect("up_pop", 3'd0);
    check("up_empty", cmd_valid, 0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_break_held", held_valid, 0);

    // LEFT with typematic repeats, then break.
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h6B);
    check("left_held_dir", held_dir, 2);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("left_break_held", held_valid, 0);
    pop_expect("left_once", 3'd2);
    check("left_only_one", cmd_valid, 0);

    // Six makes into a 4-deep FIFO: two dropped.
    send(8'h29); send(8'h76);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h72);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    check("ovf_drop", drop_count, 2);
    check("ovf_held_dir", held_dir, 3);
    check("ovf_head", cmd_data, 4);
    // Full FIFO: push PAUSE while popping the head.
    send_pop(8'h29);
    check("fullpp_drop", drop_count, 2);
    pop_expect("q0", 3'd5);
    pop_expect("q1", 3'd0);
    pop_expect("q2", 3'd1);
    pop_expect("q3", 3'd4);
    check("drained", cmd_valid, 0);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("right_break_held", held_valid, 0);

    // Drop counter saturation: 4 fill + 256 more PAUSE makes.
    for (int i = 0; i < 260; i++) send(8'h29);
    check("drop_sat", drop_count, 255);
    check("sat_full_head", cmd_data, 4);
    send(8'hE0); send(8'h72);
    check("sat_held_dir", held_dir, 1);
    check("sat_drop_stays", drop_count, 255);

    // Reset in the middle of an extended prefix.
    send(8'hE0);
    #2 reset = 1'b1;
    #2;
    check("async_rst_valid", cmd_valid, 0);
    check("async_rst_drop", drop_count, 0);
    check("async_rst_held", held_valid, 0);
    reset = 1'b0;
    @(negedge clock);
    send(8'h75);
    check("post_rst_valid", cmd_valid, 0);
    check("post_rst_data", cmd_data, 0);
    check("post_rst_held_valid", held_valid, 0);
    check("post_rst_held_dir", held_dir, 0);

    // Break of a non-held direction leaves the held key alone.
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("other_break_held", held_valid, 1);
    check("other_break_dir", held_dir, 2);
    pop_expect("left2", 3'd2);
    send(8'hE0); send(8'hF0); send(8'h6B);

    // Letter key A.
    send(8'h1C);
`ifdef PS2_WASD_EN
    check("wasd_a_held", held_valid, 1);
    pop_expect("wasd_a", 3'd2);
    // W while UP arrow held is a distinct key: pushes UP.
    send(8'hE0); send(8'h75);
    send(8'h1D);
    pop_expect("arrow_up", 3'd0);
    pop_expect("wasd_w", 3'd0);
`else
    check("wasd_off_valid", cmd_valid, 0);
    check("wasd_off_held", held_valid, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
